// File: rtl/flash_audio_player.sv
// flash_audio_player
// Streams audio samples out of a word-addressed flash (Avalon-MM read master)
// into a codec FIFO. Each flash word holds two SAMPLE_W samples. Stereo mode
// plays one word as one L/R frame. Mono mode plays the low half first and then
// the high half, with each half sent to both channels. Each frame is repeated
// 1, 2 or 4 times for normal, half or quarter speed. Samples are attenuated by
// an arithmetic right shift.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   start, pause, loop      control (start is sampled only while idle)
//   stereo, speed,
//   vol_shift               playback configuration, latched on start
//   start_addr, end_addr    inclusive word range, latched on start
//   flash_mem_*             Avalon-MM read master towards the flash
//   write_ready, write_s,
//   writedata_left/right    codec handshake and sample data
//   busy, done, cur_addr    status (done is sticky until the next start)
module flash_audio_player #(
   parameter int ADDR_W   = 23,
   parameter int SAMPLE_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  pause,
   input  logic                  loop,
   input  logic                  stereo,
   input  logic [1:0]            speed,
   input  logic [3:0]            vol_shift,
   input  logic [ADDR_W-1:0]     start_addr,
   input  logic [ADDR_W-1:0]     end_addr,
   output logic                  flash_mem_read,
   input  logic                  flash_mem_waitrequest,
   output logic [ADDR_W-1:0]     flash_mem_address,
   input  logic [2*SAMPLE_W-1:0] flash_mem_readdata,
   input  logic                  flash_mem_readdatavalid,
   output logic [3:0]            flash_mem_byteenable,
   input  logic                  write_ready,
   output logic                  write_s,
   output logic [SAMPLE_W-1:0]   writedata_left,
   output logic [SAMPLE_W-1:0]   writedata_right,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_W-1:0]     cur_addr
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_REQ, ST_WAIT_DATA, ST_WRITE, ST_WAIT_LOW, ST_NEXT, ST_DONE
   } state_t;

   state_t                state_r;
   logic                  loop_r;
   logic                  stereo_r;
   logic [1:0]            rep_last_r;
   logic [3:0]            vol_r;
   logic [ADDR_W-1:0]     start_addr_r;
   logic [ADDR_W-1:0]     end_addr_r;
   logic [ADDR_W-1:0]     cur_addr_r;
   logic                  read_r;
   logic [ADDR_W-1:0]     address_r;
   logic                  write_r;
   logic [SAMPLE_W-1:0]   wd_left_r;
   logic [SAMPLE_W-1:0]   wd_right_r;
   logic                  busy_r;
   logic                  done_r;
   logic [SAMPLE_W-1:0]   low_r;
   logic [SAMPLE_W-1:0]   high_r;
   logic                  half_r;
   logic [1:0]            rep_r;

   // Index of the last repeat of a frame: 1, 2 or 4 writes per frame.
   function automatic logic [1:0] rep_last_f(input logic [1:0] spd);
      case (spd)
         2'b01:   return 2'd1;
         2'b10:   return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   // Arithmetic right shift, so results round toward negative infinity.
   function automatic logic [SAMPLE_W-1:0] atten_f(input logic [SAMPLE_W-1:0] smp,
                                                   input logic [3:0] sh);
      logic signed [SAMPLE_W-1:0] smp_sg;
      smp_sg = $signed(smp);
      return smp_sg >>> sh;
   endfunction

   assign flash_mem_read       = read_r;
   assign flash_mem_address    = address_r;
   assign flash_mem_byteenable = 4'b1111;
   assign write_s              = write_r;
   assign writedata_left       = wd_left_r;
   assign writedata_right      = wd_right_r;
   assign busy                 = busy_r;
   assign done                 = done_r;
   assign cur_addr             = cur_addr_r;

   // Playback state machine. It drives every registered output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         loop_r       <= 1'b0;
         stereo_r     <= 1'b0;
         rep_last_r   <= 2'd0;
         vol_r        <= 4'd0;
         start_addr_r <= {ADDR_W{1'b0}};
         end_addr_r   <= {ADDR_W{1'b0}};
         cur_addr_r   <= {ADDR_W{1'b0}};
         read_r       <= 1'b0;
         address_r    <= {ADDR_W{1'b0}};
         write_r      <= 1'b0;
         wd_left_r    <= {SAMPLE_W{1'b0}};
         wd_right_r   <= {SAMPLE_W{1'b0}};
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         low_r        <= {SAMPLE_W{1'b0}};
         high_r       <= {SAMPLE_W{1'b0}};
         half_r       <= 1'b0;
         rep_r        <= 2'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  loop_r       <= loop;
                  stereo_r     <= stereo;
                  rep_last_r   <= rep_last_f(speed);
                  vol_r        <= vol_shift;
                  start_addr_r <= start_addr;
                  end_addr_r   <= end_addr;
                  done_r       <= 1'b0;
                  busy_r       <= 1'b1;
                  if (end_addr < start_addr) begin
                     state_r <= ST_DONE;
                  end else begin
                     cur_addr_r <= start_addr;
                     address_r  <= start_addr;
                     read_r     <= 1'b1;
                     state_r    <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               // The read is accepted on the first edge with waitrequest low.
               if (!flash_mem_waitrequest) begin
                  read_r  <= 1'b0;
                  state_r <= ST_WAIT_DATA;
               end
            end
            ST_WAIT_DATA: begin
               if (flash_mem_readdatavalid) begin
                  low_r   <= atten_f(flash_mem_readdata[SAMPLE_W-1:0], vol_r);
                  high_r  <= atten_f(flash_mem_readdata[2*SAMPLE_W-1:SAMPLE_W], vol_r);
                  half_r  <= 1'b0;
                  rep_r   <= 2'd0;
                  state_r <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               // pause is honoured only here, between frames.
               if (!pause && write_ready) begin
                  if (stereo_r) begin
                     wd_left_r  <= low_r;
                     wd_right_r <= high_r;
                  end else begin
                     wd_left_r  <= half_r ? high_r : low_r;
                     wd_right_r <= half_r ? high_r : low_r;
                  end
                  write_r <= 1'b1;
                  state_r <= ST_WAIT_LOW;
               end
            end
            ST_WAIT_LOW: begin
               if (!write_ready) begin
                  write_r <= 1'b0;
                  if (rep_r != rep_last_r) begin
                     rep_r   <= rep_r + 2'd1;
                     state_r <= ST_WRITE;
                  end else if (!stereo_r && !half_r) begin
                     half_r  <= 1'b1;
                     rep_r   <= 2'd0;
                     state_r <= ST_WRITE;
                  end else begin
                     state_r <= ST_NEXT;
                  end
               end
            end
            ST_NEXT: begin
               // Equality test only, so an end_addr at the top of the address
               // space never wraps before the range is finished.
               if (cur_addr_r == end_addr_r) begin
                  if (loop_r) begin
                     cur_addr_r <= start_addr_r;
                     address_r  <= start_addr_r;
                     read_r     <= 1'b1;
                     state_r    <= ST_REQ;
                  end else begin
                     state_r <= ST_DONE;
                  end
               end else begin
                  cur_addr_r <= cur_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                  address_r  <= cur_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                  read_r     <= 1'b1;
                  state_r    <= ST_REQ;
               end
            end
            ST_DONE: begin
               done_r  <= 1'b1;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               read_r  <= 1'b0;
               write_r <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/flash_audio_player.md
FLASH_AUDIO_PLAYER -- requirements
Module: flash_audio_player

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 23, flash word address width; SAMPLE_W, default 16, sample width (flash word = 2*SAMPLE_W bits).
REQ-002 Ports, clock and reset first:
  clk  in  1  system clock
  rst_n  in  1  reset; one clock; reset is asynchronous and active-low
  start  in  1  level, sampled each clk; begin playback when idle
  pause  in  1  level; hold playback at next frame boundary
  loop  in  1  wrap to start_addr after end_addr
  stereo  in  1  1: low half = left, high half = right; 0: mono, each half to both channels
  speed  in  2  00 normal, 01 half (x2 repeat), 10 quarter (x4 repeat), 11 = normal
  vol_shift  in  4  arithmetic right-shift attenuation, 0..15
  start_addr, end_addr  in  ADDR_W  inclusive word range
  flash_mem_read  out  1  Avalon read request
  flash_mem_waitrequest  in  1  Avalon wait
  flash_mem_address  out  ADDR_W  word address
  flash_mem_readdata  in  2*SAMPLE_W  read data
  flash_mem_readdatavalid  in  1  data valid strobe
  flash_mem_byteenable  out  4  constant all-ones
  write_ready  in  1  codec FIFO can accept
  write_s  out  1  codec write strobe
  writedata_left, writedata_right  out  SAMPLE_W  codec samples
  busy  out  1  playback in progress
  done  out  1  sticky; one-shot range completed
  cur_addr  out  ADDR_W  word currently playing

Function
REQ-003 FSM states SHALL be IDLE, REQ, WAIT_DATA, WRITE, WAIT_LOW, NEXT, DONE.
REQ-004 IDLE: on start=1, latch loop, stereo, speed, vol_shift, start_addr, end_addr; clear done; set busy; go REQ. Inputs other than pause SHALL be ignored while busy.
REQ-005 IDLE with start=1 and end_addr < start_addr: no flash access; go DONE.
REQ-006 REQ: flash_mem_read=1, flash_mem_address=cur_addr, held stable while waitrequest=1; the cycle after waitrequest=0 is sampled with read=1, read SHALL drop and state go WAIT_DATA.
REQ-007 WAIT_DATA: on readdatavalid=1, register both halves, each sign-extended and arithmetically shifted right by latched vol_shift; go WRITE. Shift rounds toward negative infinity (-1 >>> n = -1).
REQ-008 Frame: stereo = one word (left=low half, right=high half); mono = one half, low half first, both channels equal. Each word yields 1 (stereo) or 2 (mono) frames.
REQ-009 Each frame SHALL be written R times, R = 1, 2, 4 per latched speed.
REQ-010 WRITE: if pause=1, wait with write_s=0; else when write_ready=1 drive frame data, write_s=1, go WAIT_LOW.
REQ-011 WAIT_LOW: hold write_s=1 and data until write_ready=0, then write_s=0; next write of same word -> WRITE, else -> NEXT.
REQ-012 NEXT: if cur_addr == end_addr: loop=1 -> cur_addr=start_addr, REQ; loop=0 -> DONE. Else cur_addr+1, REQ. Equality compare only; end_addr = 2^ADDR_W-1 SHALL NOT wrap mid-range.
REQ-013 DONE: done=1, busy=0 next cycle; return IDLE. done stays 1 until next accepted start or reset.
REQ-014 pause SHALL never abort an in-flight flash read or a write already strobed.
REQ-015 Flash read latency SHALL be arbitrary; no timeout.

Reset
REQ-016 rst_n=0 SHALL immediately force state IDLE, flash_mem_read=0, flash_mem_address=0, write_s=0, writedata_left/right=0, busy=0, done=0, cur_addr=0, regardless of state, including mid-read and mid-write.
REQ-017 flash_mem_byteenable SHALL be 4'b1111 in and out of reset.

Verification
REQ-018 Mono, speed 00, vol_shift 6, range 0..1, word0=0xC000_4000 -> writes 0x0100, 0xFF00 (both channels) then word1 halves; done=1, busy=0.
REQ-019 Stereo, speed 01, word=0x8000_7FFF, vol_shift 0 -> two writes L=0x7FFF, R=0x8000; exactly one flash read.
REQ-020 loop=1, range 5..6 -> read addresses 5,6,5,6,... ; done stays 0 for 1000 writes.
REQ-021 waitrequest high 7 cycles, readdatavalid 12 cycles later -> address stable throughout, read deasserts 1 cycle after accept, single read.
REQ-022 pause raised during WAIT_LOW -> current write completes, no further write_s until pause=0; rst_n low mid-WAIT_DATA -> all outputs reset asynchronously, stale readdatavalid after release ignored.
REQ-023 end_addr=3, start_addr=4 -> no flash_mem_read, done=1 within 2 cycles.
